mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one registered 2-bit output channel between two
//  valid-qualified requesters (port 0, port 1). Each port owns a small input FIFO;
//  the arbiter drives the select, pops the winning FIFO and registers data/valid out.
//  Sits in front of the downstream consumer; supplies the select sequencing for the 2:1 path.
// PARAMETERS
//  DATA_W      2   width of data_in0/data_in1/data_out
//  FIFO_DEPTH  4   entries per input FIFO; power of 2, >=2
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  reset_L     in   1       asynchronous, active-low reset
//  valid_0     in   1       port 0 push request
//  data_in0    in   DATA_W  port 0 data, sampled when valid_0=1
//  valid_1     in   1       port 1 push request
//  data_in1    in   DATA_W  port 1 data, sampled when valid_1=1
//  out_ready   in   1       downstream accepts data_out this cycle
//  full_0      out  1       port 0 FIFO holds FIFO_DEPTH entries
//  full_1      out  1       port 1 FIFO holds FIFO_DEPTH entries
//  ovf_0       out  1       sticky: port 0 push dropped while full
//  ovf_1       out  1       sticky: port 1 push dropped while full
//  valid_out   out  1       data_out valid
//  data_out    out  DATA_W  registered output data
//  grant       out  1       source port of current data_out (0/1)
// BEHAVIOUR
//  Reset (reset_L=0, async): FIFOs empty, pointers/counts 0, full_x=0, ovf_x=0,
//   valid_out=0, data_out=0, grant=0, last_grant=1 (first contention goes to port 0).
//  Push: valid_x=1 & full_x=0 -> write at edge. valid_x=1 & full_x=1 -> dropped, ovf_x<=1
//   until reset. full_x from registered count; pop in same cycle does NOT unblock push.
//  Output stage free when valid_out=0 or out_ready=1. When free, at edge:
//   both FIFOs non-empty -> serve port != last_grant; one non-empty -> serve it;
//   none -> valid_out<=0, data_out/grant hold. Served: data_out<=head, grant<=port,
//   valid_out<=1, last_grant<=port, head popped.
//  Stall: valid_out=1 & out_ready=0 -> data_out, grant, valid_out, FIFOs' heads held.
//  Latency: push at edge N into empty FIFO, idle output -> valid_out=1 after edge N+1.
//  Throughput: one word per cycle when out_ready=1; strict alternation under contention.
//  Count/pointer wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  Simultaneous push and pop on same FIFO (not full): count unchanged, order preserved.
//  Reset asserted mid-transfer: all in-flight and queued data discarded immediately.
// CONFIGURATION
//  MUX_RR_ARB_STATS_EN defined: adds outputs gnt_cnt0, gnt_cnt1 (8 bits each), +1 per
//   word served from that port, saturate at 8'hFF, cleared by reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: drive reset_L=0 mid-traffic -> all outputs 0 same cycle, no valid_out after release.
//  2 Single port: push 0,1,2,3 on port 0, out_ready=1 -> data_out 0,1,2,3, grant=0, 1 cycle after each push.
//  3 Contention: both ports fill with 4 words (p0=2'b01, p1=2'b10), out_ready=1 -> grant 0,1,0,1,...; 8 words, no gaps.
//  4 Overflow: 5 pushes on port 1 with out_ready=0 -> full_1=1 after 4th, 5th dropped, ovf_1=1 sticky.
//  5 Stall: out_ready=0 for 3 cycles with valid_out=1 -> data_out/grant stable, released in order after.
//  6 Stats (MUX_RR_ARB_STATS_EN): 300 words on port 0 -> gnt_cnt0=8'hFF, gnt_cnt1=0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Two-port round-robin arbiter. Each requester pushes into its own small FIFO.
//   A registered output stage pulls one word per cycle from the FIFOs and presents
//   it downstream with a valid/ready handshake. Under contention the ports alternate.
//   The full flags come from the registered FIFO counts, so a pop in the same cycle
//   never lets a push through. A push that arrives while the FIFO is full is dropped,
//   and a sticky overflow flag records it until reset.
//   Optional feature: define MUX_RR_ARB_STATS_EN to add the per-port grant counters
//   gnt_cnt0 and gnt_cnt1. Each is 8 bits wide and saturates at 8'hFF.
module mux_rr_arbiter #(
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              out_ready,
  output logic              full_0,
  output logic              full_1,
  output logic              ovf_0,
  output logic              ovf_1,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              grant
`ifdef MUX_RR_ARB_STATS_EN
  ,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Saturating increment for the 8-bit grant statistics.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  // Port 0 FIFO state
  logic [DATA_W-1:0] mem0_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr0_q, wr_ptr0_d;
  logic [PTR_W-1:0]  rd_ptr0_q, rd_ptr0_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic              ovf0_q, ovf0_d;

  // Port 1 FIFO state
  logic [DATA_W-1:0] mem1_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr1_q, wr_ptr1_d;
  logic [PTR_W-1:0]  rd_ptr1_q, rd_ptr1_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              ovf1_q, ovf1_d;

  // Output stage state
  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;

  // Handshake and arbitration signals
  logic              full0, full1;
  logic              ne0, ne1;
  logic              push0, push1;
  logic              pop0, pop1;
  logic              out_free;
  logic              serve;
  logic              sel;
  logic [DATA_W-1:0] head0, head1;

  // Occupancy flags from the registered counts; a push is accepted only when not full.
  always_comb begin
    full0 = (cnt0_q == FULL_CNT);
    full1 = (cnt1_q == FULL_CNT);
    ne0   = (cnt0_q != '0);
    ne1   = (cnt1_q != '0);
    push0 = valid_0 & ~full0;
    push1 = valid_1 & ~full1;
    head0 = mem0_q[rd_ptr0_q];
    head1 = mem1_q[rd_ptr1_q];
  end

  // Round-robin choice. Under contention, serve the port that did not win last.
  always_comb begin
    out_free = ~valid_out_q | out_ready;
    if (ne0 && ne1) begin
      sel = ~last_grant_q;
    end else if (ne1) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    serve = out_free & (ne0 | ne1);
    pop0  = serve & ~sel;
    pop1  = serve &  sel;
  end

  // Next-state for both FIFOs' pointers, counts and sticky overflow flags.
  always_comb begin
    wr_ptr0_d = push0 ? wr_ptr0_q + 1'b1 : wr_ptr0_q;
    rd_ptr0_d = pop0  ? rd_ptr0_q + 1'b1 : rd_ptr0_q;
    cnt0_d    = cnt0_q + CNT_W'(push0) - CNT_W'(pop0);
    ovf0_d    = ovf0_q | (valid_0 & full0);
    wr_ptr1_d = push1 ? wr_ptr1_q + 1'b1 : wr_ptr1_q;
    rd_ptr1_d = pop1  ? rd_ptr1_q + 1'b1 : rd_ptr1_q;
    cnt1_d    = cnt1_q + CNT_W'(push1) - CNT_W'(pop1);
    ovf1_d    = ovf1_q | (valid_1 & full1);
  end

  // Output stage next-state. The stage loads when free, goes idle when there is nothing to serve, and holds during a stall.
  always_comb begin
    valid_out_d  = valid_out_q;
    data_out_d   = data_out_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (out_free) begin
      if (serve) begin
        valid_out_d  = 1'b1;
        data_out_d   = sel ? head1 : head0;
        grant_d      = sel;
        last_grant_d = sel;
      end else begin
        valid_out_d  = 1'b0;
      end
    end
  end

  // FIFO storage. Reset only clears the pointers and counts, so the contents need no reset.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem0_q[wr_ptr0_q] <= data_in0;
    end
    if (push1) begin
      mem1_q[wr_ptr1_q] <= data_in1;
    end
  end

  // FIFO control registers. Reset discards every queued word at once.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr0_q <= '0;
      rd_ptr0_q <= '0;
      cnt0_q    <= '0;
      ovf0_q    <= 1'b0;
      wr_ptr1_q <= '0;
      rd_ptr1_q <= '0;
      cnt1_q    <= '0;
      ovf1_q    <= 1'b0;
    end else begin
      wr_ptr0_q <= wr_ptr0_d;
      rd_ptr0_q <= rd_ptr0_d;
      cnt0_q    <= cnt0_d;
      ovf0_q    <= ovf0_d;
      wr_ptr1_q <= wr_ptr1_d;
      rd_ptr1_q <= rd_ptr1_d;
      cnt1_q    <= cnt1_d;
      ovf1_q    <= ovf1_d;
    end
  end

  // Output registers. last_grant resets to 1 so the first contention goes to port 0.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef MUX_RR_ARB_STATS_EN
  logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

  // Count words served per port, holding at the top value once reached.
  always_comb begin
    gnt_cnt0_d = pop0 ? sat_inc8(gnt_cnt0_q) : gnt_cnt0_q;
    gnt_cnt1_d = pop1 ? sat_inc8(gnt_cnt1_q) : gnt_cnt1_q;
  end

  // Grant statistics registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gnt_cnt0_q <= 8'h00;
      gnt_cnt1_q <= 8'h00;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

  assign full_0    = full0;
  assign full_1    = full1;
  assign ovf_0     = ovf0_q;
  assign ovf_1     = ovf1_q;
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Queue-based reference model of the two-port round-robin arbiter, compared with
//   the DUT after every clock edge. Directed scenarios with literal expectations
//   come first, followed by randomized traffic that includes mid-traffic resets.
module tb_mux_rr_arbiter;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_L;
  logic              valid_0, valid_1, out_ready;
  logic [DATA_W-1:0] data_in0, data_in1;
  logic              full_0, full_1, ovf_0, ovf_1, valid_out, grant;
  logic [DATA_W-1:0] data_out;
`ifdef MUX_RR_ARB_STATS_EN
  logic [7:0]        gnt_cnt0, gnt_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic              m_vo, m_gnt, m_last, m_ovf0, m_ovf1;
  logic [DATA_W-1:0] m_do;
  int                m_cnt0, m_cnt1;

  mux_rr_arbiter #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_L(reset_L),
    .valid_0(valid_0), .data_in0(data_in0),
    .valid_1(valid_1), .data_in1(data_in1),
    .out_ready(out_ready),
    .full_0(full_0), .full_1(full_1), .ovf_0(ovf_0), .ovf_1(ovf_1),
    .valid_out(valid_out), .data_out(data_out), .grant(grant)
`ifdef MUX_RR_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_vo   = 1'b0;
    m_do   = '0;
    m_gnt  = 1'b0;
    m_last = 1'b1;
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // One rising edge of the model. Fullness and emptiness are judged on the pre-edge occupancy.
  task automatic model_edge();
    int s0, s1, p;
    if (!reset_L) begin
      model_reset();
      return;
    end
    s0 = q0.size();
    s1 = q1.size();
    if (!m_vo || out_ready) begin
      if (s0 > 0 && s1 > 0) p = m_last ? 0 : 1;
      else if (s0 > 0)      p = 0;
      else if (s1 > 0)      p = 1;
      else                  p = -1;
      if (p == 0) begin
        m_do = q0.pop_front(); m_gnt = 1'b0; m_vo = 1'b1; m_last = 1'b0;
        if (m_cnt0 < 255) m_cnt0++;
      end else if (p == 1) begin
        m_do = q1.pop_front(); m_gnt = 1'b1; m_vo = 1'b1; m_last = 1'b1;
        if (m_cnt1 < 255) m_cnt1++;
      end else begin
        m_vo = 1'b0;
      end
    end
    if (valid_0) begin
      if (s0 == DEPTH) m_ovf0 = 1'b1;
      else             q0.push_back(data_in0);
    end
    if (valid_1) begin
      if (s1 == DEPTH) m_ovf1 = 1'b1;
      else             q1.push_back(data_in1);
    end
  endtask

  task automatic compare_all();
    chk("valid_out", 32'(valid_out), 32'(m_vo));
    chk("data_out",  32'(data_out),  32'(m_do));
    chk("grant",     32'(grant),     32'(m_gnt));
    chk("full_0",    32'(full_0),    32'(q0.size() == DEPTH));
    chk("full_1",    32'(full_1),    32'(q1.size() == DEPTH));
    chk("ovf_0",     32'(ovf_0),     32'(m_ovf0));
    chk("ovf_1",     32'(ovf_1),     32'(m_ovf1));
`ifdef MUX_RR_ARB_STATS_EN
    chk("gnt_cnt0",  32'(gnt_cnt0),  32'(m_cnt0));
    chk("gnt_cnt1",  32'(gnt_cnt1),  32'(m_cnt1));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    valid_0 = 1'b0; valid_1 = 1'b0;
    data_in0 = '0;  data_in1 = '0;
  endtask

  // Assert the reset between clock edges. The outputs must clear at once and stay quiet after release.
  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    model_reset();
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_grant",     32'(grant),     32'd0);
    chk("rst_full_ovf",  32'({full_0, full_1, ovf_0, ovf_1}), 32'd0);
    compare_all();
    step();
    reset_L = 1'b1;
    idle_inputs();
    step();
    chk("post_rst_valid", 32'(valid_out), 32'd0);
  endtask

  initial begin
    reset_L   = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    chk("init_valid_out", 32'(valid_out), 32'd0);
    chk("init_grant",     32'(grant),     32'd0);
    compare_all();
    step();
    step();
    reset_L = 1'b1;
    step();

    // Single port: each word appears one edge after its push.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid_0 = 1'b1; data_in0 = 2'(k);
      step();
      if (k > 0) begin
        chk("t2_data",  32'(data_out), 32'(k - 1));
        chk("t2_grant", 32'(grant),    32'd0);
      end
    end
    valid_0 = 1'b0;
    step();
    chk("t2_last_data",  32'(data_out),  32'd3);
    chk("t2_last_valid", 32'(valid_out), 32'd1);
    step();
    chk("t2_drained", 32'(valid_out), 32'd0);

    // Reset in the middle of traffic.
    valid_0 = 1'b1; valid_1 = 1'b1; data_in0 = 2'd2; data_in1 = 2'd1;
    step(); step(); step();
    do_reset();

    // Contention: both FIFOs fill while the output is stalled, then drain alternately.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_0 = 1'b1; data_in0 = 2'b01;
      valid_1 = 1'b1; data_in1 = 2'b10;
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    chk("t3_first_valid", 32'(valid_out), 32'd1);
    chk("t3_first_grant", 32'(grant),     32'd0);
    chk("t3_first_data",  32'(data_out),  32'h1);
    chk("t3_full_1",      32'(full_1),    32'd1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t3_valid", 32'(valid_out), 32'd1);
      chk("t3_grant", 32'(grant),     32'(i & 1));
      chk("t3_data",  32'(data_out),  (i & 1) ? 32'h2 : 32'h1);
    end
    step();
    chk("t3_done", 32'(valid_out), 32'd0);

    // Overflow on port 1 while the output stage is stalled on a port-0 word.
    out_ready = 1'b0;
    valid_0 = 1'b1; data_in0 = 2'b11;
    step();
    valid_0 = 1'b0;
    step();
    chk("t4_hold_valid", 32'(valid_out), 32'd1);
    chk("t4_hold_data",  32'(data_out),  32'd3);
    for (int k = 0; k < 5; k++) begin
      valid_1 = 1'b1; data_in1 = 2'(k);
      step();
      chk("t5_stall_data",  32'(data_out), 32'd3);
      chk("t5_stall_grant", 32'(grant),    32'd0);
      if (k == 2) chk("t4_full_after3", 32'(full_1), 32'd0);
      if (k == 3) begin
        chk("t4_full_after4", 32'(full_1), 32'd1);
        chk("t4_ovf_after4",  32'(ovf_1),  32'd0);
      end
      if (k == 4) chk("t4_ovf_after5", 32'(ovf_1), 32'd1);
    end
    idle_inputs();
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_release_data",  32'(data_out), 32'(k));
      chk("t5_release_grant", 32'(grant),    32'd1);
    end
    step();
    chk("t5_release_done", 32'(valid_out), 32'd0);
    chk("t4_ovf_sticky",   32'(ovf_1),     32'd1);
    do_reset();

    // Randomized traffic with varying densities, with a reset between blocks.
    for (int blk = 0; blk < 4; blk++) begin
      int p0, p1, pr;
      p0 = 25 + 25 * blk;
      p1 = 100 - 20 * blk;
      pr = (blk % 2 == 0) ? 70 : 35;
      for (int cyc = 0; cyc < 400; cyc++) begin
        valid_0   = ($urandom_range(0, 99) < p0);
        valid_1   = ($urandom_range(0, 99) < p1);
        data_in0  = 2'($urandom);
        data_in1  = 2'($urandom);
        out_ready = ($urandom_range(0, 99) < pr);
        step();
      end
      do_reset();
    end

`ifdef MUX_RR_ARB_STATS_EN
    // Grant statistics saturate after more than 255 words.
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      valid_0 = 1'b1; data_in0 = 2'(i);
      step();
    end
    idle_inputs();
    step();
    step();
    chk("t6_gnt_cnt0", 32'(gnt_cnt0), 32'hFF);
    chk("t6_gnt_cnt1", 32'(gnt_cnt1), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
